// File: rtl/cpu_mem_bridge.sv
// Data-side bridge for the CPU memory stage: RAM port plus an I/O window holding a
// result FIFO to the host, an operand mailbox from the host, and status/control registers.
module cpu_mem_bridge #(
    parameter int unsigned RAM_AW     = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [9:0] OFF_OUT    = 10'd0;
    localparam logic [9:0] OFF_STATUS = 10'd1;
    localparam logic [9:0] OFF_IN     = 10'd2;
    localparam logic [9:0] OFF_CTRL   = 10'd3;

    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             mboxValid;
    logic [31:0]      mboxData;

    logic       ioSel;
    logic [9:0] offset;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       pushReq;
    logic       popReq;
    logic       pushAccept;
    logic       overflowSet;
    logic       ctrlWrite;
    logic       unusedAddrLsb;

    assign ioSel         = (ALUResult[31:12] == IO_BASE[31:12]);
    assign offset        = ALUResult[11:2];
    assign unusedAddrLsb = ^ALUResult[1:0];

    assign ram_addr  = ALUResult[RAM_AW+1:2];
    assign ram_wdata = WriteData;
    assign ram_we    = MemWrite & ~ioSel;

    assign fifoEmpty   = (count == '0);
    assign fifoFull    = (count == CNT_W'(FIFO_DEPTH));
    assign pushReq     = MemWrite & ioSel & (offset == OFF_OUT);
    assign popReq      = out_valid & out_ready;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign pushAccept  = pushReq & (~fifoFull | popReq);
    assign overflowSet = pushReq & fifoFull & ~popReq;
    assign ctrlWrite   = MemWrite & ioSel & (offset == OFF_CTRL);

    assign out_valid = ~fifoEmpty;
    assign out_data  = fifoMem[rdPtr];
    assign in_ready  = ~mboxValid;

    always_comb begin
        ReadData = ram_rdata;
        if (ioSel) begin
            ReadData = '0;
            case (offset)
                OFF_STATUS: ReadData = {16'h0000, 8'(count), 4'h0,
                                        mboxValid, overflow, fifoFull, fifoEmpty};
                OFF_IN:     ReadData = mboxData;
                default:    ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifoMem[i] <= '0;
            end
        end else begin
            if (pushAccept) begin
                fifoMem[wrPtr] <= WriteData;
                wrPtr          <= wrPtr + PTR_W'(1);
            end
            if (popReq) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (pushAccept && !popReq) begin
                count <= count + CNT_W'(1);
            end else if (!pushAccept && popReq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (overflowSet) begin
            overflow <= 1'b1;
        end else if (ctrlWrite && WriteData[0]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mboxValid <= 1'b0;
            mboxData  <= '0;
        end else if (in_valid && !mboxValid) begin
            mboxValid <= 1'b1;
            mboxData  <= in_data;
        end else if (ctrlWrite && WriteData[1]) begin
            mboxValid <= 1'b0;
        end
    end

endmodule
